// File: rtl/l2_cache_wb_pkg.sv
// Shared types for the write-back L2: FSM states, per-way metadata and
// address-field width helpers.
package l2_cache_pkg;

  // Metadata fields are sized for the largest supported geometry.
  localparam int unsigned TAG_MAX = 32;
  localparam int unsigned AGE_MAX = 8;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    WRITEBACK,
    REFILL,
    RESP
  } state_t;

  typedef struct packed {
    logic               valid;
    logic               dirty;
    logic [TAG_MAX-1:0] tag;
    logic [AGE_MAX-1:0] age;
  } meta_t;

  function automatic int unsigned off_bits(input int unsigned block_words);
    return $clog2(block_words);
  endfunction

  function automatic int unsigned idx_bits(input int unsigned num_sets);
    return $clog2(num_sets);
  endfunction

  function automatic int unsigned tag_bits(input int unsigned addr_w,
                                           input int unsigned num_sets,
                                           input int unsigned block_words);
    return addr_w - idx_bits(num_sets) - off_bits(block_words);
  endfunction

endpackage

// File: rtl/l2_cache_wb_if.sv
// L1-side and memory-side block bus of the L2 cache.
interface l2_cache_wb_if #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH  = 11,
  parameter int unsigned BLOCK_WORDS = 8
);
  logic [ADDR_WIDTH-1:0]                   l1_addr;
  logic [BLOCK_WORDS-1:0][DATA_WIDTH-1:0]  l1_wdata;
  logic                                    l1_read;
  logic                                    l1_write;
  logic                                    l1_ready;
  logic                                    l1_valid;
  logic                                    l1_hit;
  logic [BLOCK_WORDS-1:0][DATA_WIDTH-1:0]  l1_rdata;
  logic [ADDR_WIDTH-1:0]                   mem_addr;
  logic [BLOCK_WORDS-1:0][DATA_WIDTH-1:0]  mem_wdata;
  logic                                    mem_read;
  logic                                    mem_write;
  logic [BLOCK_WORDS-1:0][DATA_WIDTH-1:0]  mem_rdata;
  logic                                    mem_ready;

  modport slave (
    input  l1_addr, l1_wdata, l1_read, l1_write, mem_rdata, mem_ready,
    output l1_ready, l1_valid, l1_hit, l1_rdata,
           mem_addr, mem_wdata, mem_read, mem_write
  );

  modport master (
    output l1_addr, l1_wdata, l1_read, l1_write, mem_rdata, mem_ready,
    input  l1_ready, l1_valid, l1_hit, l1_rdata,
           mem_addr, mem_wdata, mem_read, mem_write
  );
endinterface

// File: rtl/l2_cache_wb_lru_ctrl.sv
// True-LRU age update and victim selection for one set.
module l2_lru_ctrl
  import l2_cache_pkg::*;
#(
  parameter int unsigned NUM_WAYS = 4,
  parameter int unsigned WAY_W    = $clog2(NUM_WAYS)
) (
  input  logic [NUM_WAYS-1:0][AGE_MAX-1:0] ages_in,
  input  logic [NUM_WAYS-1:0]              valid,
  input  logic [WAY_W-1:0]                 acc_way,
  output logic [NUM_WAYS-1:0][AGE_MAX-1:0] ages_out,
  output logic [WAY_W-1:0]                 victim
);
  logic [AGE_MAX-1:0] acc_age;
  logic               found;

  always_comb begin
    acc_age  = ages_in[acc_way];
    ages_out = ages_in;
    for (int unsigned w = 0; w < NUM_WAYS; w++) begin
      if (WAY_W'(w) == acc_way)
        ages_out[w] = '0;
      else if (ages_in[w] < acc_age)
        ages_out[w] = ages_in[w] + AGE_MAX'(1);
    end
  end

  // Lowest-index invalid way first, otherwise the oldest way.
  always_comb begin
    victim = '0;
    found  = 1'b0;
    for (int unsigned w = 0; w < NUM_WAYS; w++) begin
      if (!found && !valid[w]) begin
        victim = WAY_W'(w);
        found  = 1'b1;
      end
    end
    if (!found) begin
      for (int unsigned w = 0; w < NUM_WAYS; w++) begin
        if (ages_in[w] == AGE_MAX'(NUM_WAYS - 1))
          victim = WAY_W'(w);
      end
    end
  end
endmodule

// File: rtl/l2_cache_wb.sv
// Set-associative write-back/write-allocate L2 with true-LRU replacement.
// Define L2_PERF_CNT_EN to add saturating hit/miss/writeback counters.
module l2_cache_wb
  import l2_cache_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH  = 11,
  parameter int unsigned BLOCK_WORDS = 8,
  parameter int unsigned NUM_SETS    = 4,
  parameter int unsigned NUM_WAYS    = 4
) (
  input  logic        clk,
  input  logic        rst,
  l2_cache_wb_if.slave bus
`ifdef L2_PERF_CNT_EN
  ,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt,
  output logic [31:0] wb_cnt
`endif
);
  localparam int unsigned OFF_W = off_bits(BLOCK_WORDS);
  localparam int unsigned IDX_W = idx_bits(NUM_SETS);
  localparam int unsigned TAG_W = tag_bits(ADDR_WIDTH, NUM_SETS, BLOCK_WORDS);
  localparam int unsigned WAY_W = $clog2(NUM_WAYS);

  typedef logic [BLOCK_WORDS-1:0][DATA_WIDTH-1:0] block_t;

  state_t                state;
  meta_t                 meta   [NUM_SETS][NUM_WAYS];
  block_t                data_q [NUM_SETS][NUM_WAYS];
  logic [ADDR_WIDTH-1:0] req_addr;
  block_t                req_wdata;
  logic                  req_write;
  logic [WAY_W-1:0]      way_q;

  logic [IDX_W-1:0]                 req_idx;
  logic [TAG_W-1:0]                 req_tag;
  logic [NUM_WAYS-1:0]              way_hit, set_valid;
  logic [NUM_WAYS-1:0][AGE_MAX-1:0] set_ages, new_ages;
  logic [WAY_W-1:0]                 hit_way, victim, acc_way;
  logic                             any_hit, victim_dirty;
  logic                             data_we;
  logic [WAY_W-1:0]                 data_way;
  block_t                           data_val;

  assign req_idx = req_addr[OFF_W +: IDX_W];
  assign req_tag = req_addr[ADDR_WIDTH-1 -: TAG_W];

  always_comb begin
    way_hit   = '0;
    set_valid = '0;
    set_ages  = '0;
    hit_way   = '0;
    for (int unsigned w = 0; w < NUM_WAYS; w++) begin
      set_valid[w] = meta[req_idx][w].valid;
      set_ages[w]  = meta[req_idx][w].age;
      way_hit[w]   = meta[req_idx][w].valid && (meta[req_idx][w].tag == TAG_MAX'(req_tag));
      if (way_hit[w])
        hit_way = WAY_W'(w);
    end
  end

  assign any_hit      = |way_hit;
  assign acc_way      = any_hit ? hit_way : victim;
  assign victim_dirty = meta[req_idx][victim].valid && meta[req_idx][victim].dirty;

  l2_lru_ctrl #(.NUM_WAYS(NUM_WAYS), .WAY_W(WAY_W)) u_lru (
    .ages_in  (set_ages),
    .valid    (set_valid),
    .acc_way  (acc_way),
    .ages_out (new_ages),
    .victim   (victim)
  );

  always_comb begin
    data_we  = 1'b0;
    data_way = way_q;
    data_val = req_wdata;
    case (state)
      LOOKUP: if (req_write && (any_hit || !victim_dirty)) begin
        data_we  = 1'b1;
        data_way = acc_way;
      end
      WRITEBACK: data_we = bus.mem_ready && req_write;
      REFILL: begin
        data_we  = bus.mem_ready;
        data_val = bus.mem_rdata;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (data_we)
      data_q[req_idx][data_way] <= data_val;
  end

  // Ages are committed in LOOKUP for misses too; the installed way is fixed
  // there and nothing else touches the set until the request completes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      bus.l1_ready  <= 1'b1;
      bus.l1_valid  <= 1'b0;
      bus.l1_hit    <= 1'b0;
      bus.l1_rdata  <= '0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.mem_read  <= 1'b0;
      bus.mem_write <= 1'b0;
      req_addr      <= '0;
      req_wdata     <= '0;
      req_write     <= 1'b0;
      way_q         <= '0;
      for (int unsigned s = 0; s < NUM_SETS; s++)
        for (int unsigned w = 0; w < NUM_WAYS; w++)
          meta[s][w] <= '{valid: 1'b0, dirty: 1'b0, tag: '0, age: AGE_MAX'(w)};
    end else begin
      case (state)
        IDLE: if (bus.l1_read || bus.l1_write) begin
          req_addr     <= bus.l1_addr;
          req_wdata    <= bus.l1_wdata;
          req_write    <= bus.l1_write;
          bus.l1_ready <= 1'b0;
          state        <= LOOKUP;
        end
        LOOKUP: begin
          way_q <= acc_way;
          for (int unsigned w = 0; w < NUM_WAYS; w++)
            meta[req_idx][w].age <= new_ages[w];
          if (any_hit) begin
            bus.l1_hit   <= 1'b1;
            bus.l1_valid <= 1'b1;
            state        <= RESP;
            if (req_write)
              meta[req_idx][hit_way].dirty <= 1'b1;
            else
              bus.l1_rdata <= data_q[req_idx][hit_way];
          end else if (victim_dirty) begin
            bus.mem_write <= 1'b1;
            bus.mem_addr  <= ADDR_WIDTH'({meta[req_idx][victim].tag, req_idx, {OFF_W{1'b0}}});
            bus.mem_wdata <= data_q[req_idx][victim];
            state         <= WRITEBACK;
          end else if (req_write) begin
            meta[req_idx][victim].valid <= 1'b1;
            meta[req_idx][victim].dirty <= 1'b1;
            meta[req_idx][victim].tag   <= TAG_MAX'(req_tag);
            bus.l1_valid                <= 1'b1;
            state                       <= RESP;
          end else begin
            bus.mem_read <= 1'b1;
            bus.mem_addr <= req_addr & ~ADDR_WIDTH'(BLOCK_WORDS - 1);
            state        <= REFILL;
          end
        end
        WRITEBACK: if (bus.mem_ready) begin
          bus.mem_write <= 1'b0;
          if (req_write) begin
            meta[req_idx][way_q].valid <= 1'b1;
            meta[req_idx][way_q].dirty <= 1'b1;
            meta[req_idx][way_q].tag   <= TAG_MAX'(req_tag);
            bus.l1_valid               <= 1'b1;
            state                      <= RESP;
          end else begin
            bus.mem_read <= 1'b1;
            bus.mem_addr <= req_addr & ~ADDR_WIDTH'(BLOCK_WORDS - 1);
            state        <= REFILL;
          end
        end
        REFILL: if (bus.mem_ready) begin
          bus.mem_read               <= 1'b0;
          bus.l1_rdata               <= bus.mem_rdata;
          meta[req_idx][way_q].valid <= 1'b1;
          meta[req_idx][way_q].dirty <= 1'b0;
          meta[req_idx][way_q].tag   <= TAG_MAX'(req_tag);
          bus.l1_valid               <= 1'b1;
          state                      <= RESP;
        end
        RESP: begin
          bus.l1_valid <= 1'b0;
          bus.l1_hit   <= 1'b0;
          bus.l1_ready <= 1'b1;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef L2_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
      wb_cnt   <= '0;
    end else begin
      if (state == LOOKUP && any_hit && hit_cnt != '1)
        hit_cnt <= hit_cnt + 32'd1;
      if (state == LOOKUP && !any_hit && miss_cnt != '1)
        miss_cnt <= miss_cnt + 32'd1;
      if (state == WRITEBACK && bus.mem_ready && wb_cnt != '1)
        wb_cnt <= wb_cnt + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_l2_cache_wb.sv
// Scoreboard bench for l2_cache_wb: directed requests, queue-based L1 and memory checks.
module tb_l2_cache_wb;
  typedef logic [7:0][31:0] block_t;

  typedef struct {
    bit          wr;
    bit          hit;
    int          widx;
    logic [31:0] word;
  } exp_t;

  typedef struct {
    bit          wr;
    logic [10:0] addr;
    block_t      wdata;
    block_t      rdata;
  } mexp_t;

  logic clk = 1'b0;
  logic rst;
  bit   mem_hold;
  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t  sb_q[$];
  mexp_t mem_q[$];

  always #5 clk = ~clk;

  l2_cache_wb_if #(.DATA_WIDTH(32), .ADDR_WIDTH(11), .BLOCK_WORDS(8)) bus ();

`ifdef L2_PERF_CNT_EN
  logic [31:0] hit_cnt, miss_cnt, wb_cnt;
`endif

  l2_cache_wb #(
    .DATA_WIDTH(32), .ADDR_WIDTH(11), .BLOCK_WORDS(8), .NUM_SETS(4), .NUM_WAYS(4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
`ifdef L2_PERF_CNT_EN
    ,
    .hit_cnt  (hit_cnt),
    .miss_cnt (miss_cnt),
    .wb_cnt   (wb_cnt)
`endif
  );

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic block_t pat(input logic [31:0] base);
    block_t b;
    for (int i = 0; i < 8; i++) b[i] = base ^ 32'(i);
    return b;
  endfunction

  task automatic mexp(input bit wr, input logic [10:0] a, input block_t wd, input block_t rd);
    mem_q.push_back('{wr, a, wd, rd});
  endtask

  task automatic do_req(input bit wr, input logic [10:0] a, input block_t wd,
                        input bit eh, input int widx, input logic [31:0] ew, input int elat);
    int n;
    int lat;
    sb_q.push_back('{wr, eh, widx, ew});
    n = 0;
    while (!bus.l1_ready && n < 100) begin @(negedge clk); n++; end
    bus.l1_addr  = a;
    bus.l1_wdata = wd;
    bus.l1_write = wr;
    bus.l1_read  = !wr;
    @(posedge clk); #1;
    bus.l1_read  = 1'b0;
    bus.l1_write = 1'b0;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!bus.l1_valid && lat < 200);
    if (!bus.l1_valid) begin
      n_checks++; n_fail++;
      $display("FAIL req_timeout: addr %h got no l1_valid within %0d cycles, expected one", a, lat);
    end else if (elat > 0) begin
      chk("latency", 256'(lat), 256'(elat));
    end
    @(negedge clk);
  endtask

  // L1 response monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && bus.l1_valid) begin
        if (sb_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL l1_unexpected: got l1_valid with hit=%0b, expected none", bus.l1_hit);
        end else begin
          e = sb_q.pop_front();
          chk("l1_hit", bus.l1_hit, e.hit);
          if (!e.wr) chk("l1_rdata", bus.l1_rdata[e.widx], e.word);
        end
      end
    end
  end

  // Memory model and memory-side checker
  initial begin
    mexp_t m;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (!rst && !mem_hold && (bus.mem_read || bus.mem_write)) begin
        chk("mem_excl", bus.mem_read & bus.mem_write, 1'b0);
        if (mem_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL mem_unexpected: got request rd=%0b wr=%0b addr %h, expected none",
                   bus.mem_read, bus.mem_write, bus.mem_addr);
          bus.mem_rdata = '0;
        end else begin
          m = mem_q.pop_front();
          chk("mem_op", bus.mem_write, m.wr);
          chk("mem_addr", bus.mem_addr, m.addr);
          if (m.wr) chk("mem_wdata", bus.mem_wdata, m.wdata);
          bus.mem_rdata = m.rdata;
        end
        bus.mem_ready = 1'b1;
        @(posedge clk); #1;
        bus.mem_ready = 1'b0;
      end
    end
  end

  initial begin
    logic [10:0] a;
    logic [31:0] base;
    int          n;
    rst          = 1'b1;
    mem_hold     = 1'b0;
    bus.l1_read  = 1'b0;
    bus.l1_write = 1'b0;
    bus.l1_addr  = '0;
    bus.l1_wdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_l1_ready", bus.l1_ready, 1'b1);
    chk("rst_l1_valid", bus.l1_valid, 1'b0);
    chk("rst_l1_hit", bus.l1_hit, 1'b0);
    chk("rst_mem_rw", {bus.mem_read, bus.mem_write}, 2'b00);
    chk("rst_l1_rdata", bus.l1_rdata, '0);
    chk("rst_mem_wdata", bus.mem_wdata, '0);
    chk("rst_mem_addr", bus.mem_addr, '0);
    rst = 1'b0;
    @(negedge clk);

    // Clean read miss, then hit in the same block
    mexp(0, 11'h008, '0, pat(32'hDEADBEEF));
    do_req(0, 11'h00A, '0, 0, 0, 32'hDEADBEEF, 0);
    do_req(0, 11'h00F, '0, 1, 3, 32'hDEADBEEC, 2);

    // Write miss installs without refill; read back hits
    do_req(1, 11'h014, pat(32'hA5A5A5A5), 0, 0, 0, 2);
    do_req(0, 11'h010, '0, 1, 0, 32'hA5A5A5A5, 2);

    // Fill index 2 with dirty blocks; fifth tag evicts tag 0
    do_req(1, 11'h010, pat(32'hB0000000), 1, 0, 0, 2);
    for (int t = 1; t < 4; t++)
      do_req(1, 11'(t * 32 + 16), pat(32'hB0000000 + 32'(t) * 32'h100), 0, 0, 0, 2);
    mexp(1, 11'h010, pat(32'hB0000000), '0);
    do_req(1, 11'h090, pat(32'hB0000400), 0, 0, 0, 0);
    // Tag 0 now misses: tag 1 is written back, then tag 0 refills
    mexp(1, 11'h030, pat(32'hB0000100), '0);
    mexp(0, 11'h010, '0, pat(32'hB0000000));
    do_req(0, 11'h010, '0, 0, 5, 32'hB0000005, 0);

    // LRU at index 1: tags 0..3, touch tag 0, tag 4 evicts tag 1
    do_req(0, 11'h008, '0, 1, 0, 32'hDEADBEEF, 2);
    for (int t = 1; t < 4; t++) begin
      a    = 11'(t * 32 + 8);
      base = 32'hC0000000 | (32'(a) << 8);
      mexp(0, a, '0, pat(base));
      do_req(0, a, '0, 0, 2, base ^ 32'd2, 0);
    end
    do_req(0, 11'h008, '0, 1, 1, 32'hDEADBEEE, 2);
    base = 32'hC0000000 | (32'h088 << 8);
    mexp(0, 11'h088, '0, pat(base));
    do_req(0, 11'h088, '0, 0, 7, base ^ 32'd7, 0);
    do_req(0, 11'h008, '0, 1, 0, 32'hDEADBEEF, 2);
    base = 32'hC0000000 | (32'h028 << 8);
    mexp(0, 11'h028, '0, pat(base));
    do_req(0, 11'h028, '0, 0, 4, base ^ 32'd4, 0);

    // Reset while a refill is pending
    mem_hold = 1'b1;
    n = 0;
    while (!bus.l1_ready && n < 100) begin @(negedge clk); n++; end
    bus.l1_addr = 11'h7C0;
    bus.l1_read = 1'b1;
    @(posedge clk); #1;
    bus.l1_read = 1'b0;
    n = 0;
    while (!bus.mem_read && n < 50) begin @(negedge clk); n++; end
    chk("pre_rst_mem_read", bus.mem_read, 1'b1);
    chk("pre_rst_mem_addr", bus.mem_addr, 11'h7C0);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_mem_read", bus.mem_read, 1'b0);
    chk("mid_rst_l1_ready", bus.l1_ready, 1'b1);
    @(negedge clk);
    rst      = 1'b0;
    mem_hold = 1'b0;
    @(negedge clk);
    mexp(0, 11'h008, '0, pat(32'h12345678));
    do_req(0, 11'h00A, '0, 0, 1, 32'h12345679, 0);

    repeat (5) @(negedge clk);
    chk("sb_drained", 256'(sb_q.size()), 256'(0));
    chk("mem_drained", 256'(mem_q.size()), 256'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/l2_cache_wb.md
# l2_cache_wb

Parametrised set-associative, write-back, write-allocate L2 cache with true-LRU replacement and dirty-victim writeback. It sits between the L1 cache (block-granular requests) and main memory (block-granular request/ready handshake). It generalises the fixed-geometry L2 in set count, way count and block length. It adds dirty tracking, victim writeback and refill-free full-block write allocation.

## Interface
- DATA_WIDTH, 32, word width
- ADDR_WIDTH, 11, word address width; split as tag | index | offset
- BLOCK_WORDS, 8, words per block (power of 2); offset = log2(BLOCK_WORDS) bits
- NUM_SETS, 4, sets (power of 2); index = log2(NUM_SETS) bits
- NUM_WAYS, 4, ways per set (power of 2, ≥2)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- l1_addr  in  ADDR_WIDTH  request word address; offset bits ignored
- l1_wdata  in  BLOCK_WORDS×DATA_WIDTH  full block to write
- l1_read  in  1  read request
- l1_write  in  1  write request; wins over l1_read if both high
- l1_ready  out  1  high only in IDLE; request accepted on an edge where ready and (read or write) are high
- l1_valid  out  1  one-cycle response/ack pulse
- l1_hit  out  1  qualifies l1_valid: original lookup hit
- l1_rdata  out  BLOCK_WORDS×DATA_WIDTH  read block; valid with l1_valid on reads
- mem_addr  out  ADDR_WIDTH  block address, offset bits zero
- mem_wdata  out  BLOCK_WORDS×DATA_WIDTH  victim block
- mem_read / mem_write  out  1  level requests, held until mem_ready
- mem_rdata  in  BLOCK_WORDS×DATA_WIDTH  refill block, sampled when mem_read && mem_ready
- mem_ready  in  1  completes the current memory transfer

## Operation
- FSM: IDLE → LOOKUP → (hit) RESP; miss → WRITEBACK if victim valid&dirty, else REFILL (read) or RESP (write); WRITEBACK → REFILL (read) / RESP (write) on mem_ready; REFILL → RESP on mem_ready; RESP → IDLE.
- IDLE registers addr, wdata and op on acceptance.
- LOOKUP compares all ways' tags at the registered index.
- Read hit: block → l1_rdata; way becomes MRU.
- Write hit: block overwritten, dirty=1, MRU.
- Victim selection: lowest-index invalid way; else the way with age NUM_WAYS-1.
- Write miss: no refill. Optional writeback, then install l1_wdata with valid=1, dirty=1, MRU.
- Read miss: optional writeback, refill from mem_rdata, dirty=0, MRU. l1_rdata = refilled block.
- LRU: per-way age of log2(NUM_WAYS) bits. On access, accessed way → 0; ways younger than its old age +1. Ages stay a permutation.
- RESP: l1_valid=1; l1_hit = LOOKUP result; l1_ready=0.
- mem_read and mem_write are never high together. mem_addr = {victim tag, index, 0} in WRITEBACK and {req tag, index, 0} in REFILL.

## Timing
- Reset state: IDLE.
- Reset outputs: l1_ready=1; l1_valid, l1_hit, mem_read, mem_write = 0; l1_rdata, mem_wdata, mem_addr = 0.
- Reset contents: all valid/dirty=0; way w age = w.
- Hit latency: accept at edge E0, LOOKUP cycle, l1_valid high in the cycle after E1, l1_ready high again after E2.
- Miss latency = hit latency + one cycle per memory phase after mem_ready is sampled. mem_ready held low stalls indefinitely.
- mem_ready while no memory request is high: ignored.
- Reset asserted mid-transfer: mem_read/mem_write drop immediately (async). Dirty data is discarded.
- Requests while l1_ready=0: ignored, not queued.

## Configuration
- L2_PERF_CNT_EN defined: adds outputs hit_cnt, miss_cnt, wb_cnt (32-bit each), counted in LOOKUP and WRITEBACK completion. They saturate at 0xFFFFFFFF and reset to 0.
- Undefined: ports and logic absent; all other behaviour identical.

## Structure
- Package l2_cache_pkg holds:
  - FSM state enum: IDLE, LOOKUP, WRITEBACK, REFILL, RESP.
  - Address-field width localparam functions.
  - Per-way metadata struct: valid, dirty, tag, age.
- Sub-module l2_lru_ctrl handles one set's age vector: update on access, victim select. It is instantiated once, muxed by index.

## Test plan
Defaults: offset 3 bits, index 2 bits, tag 6 bits.
- Read miss, clean: read 0x00A → mem_read with mem_addr=0x008. Return words 0xDEADBEEF^i → l1_valid=1, l1_hit=0, l1_rdata[0]=0xDEADBEEF.
- Read hit: read 0x00F → l1_valid 2 cycles after accept, l1_hit=1, no memory activity, l1_rdata[3]=0xDEADBEEC.
- Write miss, no refill: write 0x014 with 0xA5A5A5A5^i → no mem_read, no mem_write, l1_hit=0. A following read of 0x010 hits with word0=0xA5A5A5A5.
- Dirty eviction: write tags 0..4 at index 2 (0x010, 0x030, 0x050, 0x070, 0x090). The fifth write gives mem_write with mem_addr=0x010 and mem_wdata = the first block.
- LRU: fill index 1 with tags 0–3, reread tag 0, miss tag 4 → tag 1 evicted; tag 0 still hits.
- Reset mid-REFILL: assert rst while mem_read=1 → mem_read=0 at once, l1_ready=1, and the previously valid block misses.
